// File: rtl/trig_counter_pkg.sv
// trig_counter_pkg: shared constants and latency helper for trig_counter.
// Latency depends on the TRIG_COUNTER_SYNC_EN build option.
package trig_counter_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int WIDTH_DEFAULT = 4;
  function automatic int trig_latency();
`ifdef TRIG_COUNTER_SYNC_EN
    return SYNC_STAGES + 1;
`else
    return 1;
`endif
  endfunction
endpackage

// File: rtl/trig_edge_det.sv
// trig_edge_det: optional trigger synchronizer plus rising-edge detector.
// TRIG_COUNTER_SYNC_EN adds a SYNC_STAGES-deep synchronizer in front of the history flop.
module trig_edge_det
  import trig_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_trig,
  output logic o_edge
);
  logic w_trig_c;
  logic r_trig_d;
`ifdef TRIG_COUNTER_SYNC_EN
  logic [SYNC_STAGES-1:0] r_sync;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], i_trig};
  assign w_trig_c = r_sync[SYNC_STAGES-1];
`else
  assign w_trig_c = i_trig;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_trig_d <= 1'b0;
    else      r_trig_d <= w_trig_c;
  assign o_edge = w_trig_c & ~r_trig_d;
endmodule

// File: rtl/trig_counter.sv
// trig_counter: counts rising edges of trig modulo 2^WIDTH.
// Build option TRIG_COUNTER_SYNC_EN inserts a 2-flop input synchronizer.
module trig_counter
  import trig_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  output logic [WIDTH-1:0] count
);
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("trig_counter: WIDTH must be in 1..32");
  end
  logic             w_edge;
  logic [WIDTH-1:0] r_count;
  trig_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_trig (trig),
    .o_edge (w_edge)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst)        r_count <= '0;
    else if (w_edge) r_count <= r_count + WIDTH'(1);
  assign count = r_count;
endmodule

// File: tb/tb_trig_counter.sv
// tb_trig_counter: directed self-checking bench for trig_counter.
// Works in both builds; expected timing follows trig_latency().
module tb_trig_counter;
  import trig_counter_pkg::*;
  localparam int W = 4;
  localparam int LAT = trig_latency();
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trig = 1'b0;
  logic [W-1:0] count;
  logic [W-1:0] exp_cnt = '0;
  int n_checks = 0;
  int n_errors = 0;

  trig_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .trig  (trig),
    .count (count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    trig = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    trig = 1'b1;
    repeat (hi) @(negedge clk);
    trig = 1'b0;
    repeat (lo) @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (count !== '0) begin
      n_errors++;
      $display("FAIL reset_async: count=%0d expected 0", count);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trig = ~trig;
      n_checks++;
      if (count !== '0) begin
        n_errors++;
        $display("FAIL reset_hold[%0d]: count=%0d expected 0", i, count);
      end
    end
    trig = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (count !== '0) begin
        n_errors++;
        $display("FAIL reset_release[%0d]: count=%0d expected 0", i, count);
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [W-1:0] want;
    trig = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) trig = 1'b0;
      want = (k >= LAT) ? W'(1) : W'(0);
      n_checks++;
      if (count !== want) begin
        n_errors++;
        $display("FAIL single_pulse[cyc %0d]: count=%0d expected %0d", k, count, want);
      end
    end
    exp_cnt = 1;
  endtask

  task automatic test_wrap();
    int hi_tab[17] = '{1, 3, 5, 2, 4, 1, 1, 5, 3, 2, 4, 1, 2, 5, 3, 1, 4};
    int lo_tab[17] = '{2, 1, 4, 5, 1, 3, 2, 1, 5, 4, 1, 2, 3, 1, 2, 5, 1};
    do_reset();
    for (int i = 0; i < 17; i++) begin
      pulse(hi_tab[i], lo_tab[i]);
      repeat (LAT) @(negedge clk);
      n_checks++;
      if (count !== W'((i + 1) % 16)) begin
        n_errors++;
        $display("FAIL wrap[%0d]: count=%0d expected %0d", i, count, (i + 1) % 16);
      end
    end
    n_checks++;
    if (count !== W'(1)) begin
      n_errors++;
      $display("FAIL wrap_final: count=%0d expected 1", count);
    end
  endtask

  task automatic test_min_width();
    do_reset();
    for (int i = 0; i < 8; i++) pulse(1, 1);
    repeat (LAT + 1) @(negedge clk);
    n_checks++;
    if (count !== W'(8)) begin
      n_errors++;
      $display("FAIL min_width: count=%0d expected 8", count);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 6; i++) pulse(2, 2);
    repeat (LAT) @(negedge clk);
    n_checks++;
    if (count !== W'(6)) begin
      n_errors++;
      $display("FAIL mid_reset_pre: count=%0d expected 6", count);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (count !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_async: count=%0d expected 0", count);
    end
    #1 rst = 1'b1;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    pulse(2, 2);
    repeat (LAT) @(negedge clk);
    n_checks++;
    if (count !== W'(1)) begin
      n_errors++;
      $display("FAIL mid_reset_next: count=%0d expected 1", count);
    end
  endtask

  task automatic test_held_level();
    logic [W-1:0] start;
    start = count;
    trig = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (count !== start + 1'b1) begin
      n_errors++;
      $display("FAIL held_high: count=%0d expected %0d", count, start + 1'b1);
    end
    trig = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    n_checks++;
    if (count !== start + 1'b1) begin
      n_errors++;
      $display("FAIL held_after_fall: count=%0d expected %0d", count, start + 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_wrap();
    test_min_width();
    test_mid_reset();
    test_held_level();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
